// File: rtl/rsp_arbiter_n.sv
// rsp_arbiter_n: merges CH_NUM response producers onto one response-FIFO write port.
// Each channel pushes into a private circular buffer. One buffered word per cycle is
// granted to the registered output. Grants stop while the downstream is almost full.
//
// Ports:
//   clk, rst_n        clock; synchronous active-low reset
//   rsp_write_en_i    per-channel push strobe (bit i = channel i)
//   rsp_data_i        per-channel push data, channel i at [i*RSP_WIDTH +: RSP_WIDTH]
//   ch_full_o         channel buffer holds BUF_DEPTH words
//   ovf_o             sticky per-channel "push dropped" flag
//   ovf_clr           clears all ovf_o bits; a same-cycle overflow still sets its bit
//   rsp_full          downstream almost-full; blocks new grants
//   rsp_write_en      registered write strobe to the response FIFO
//   rsp_data          registered write data, zero when no write
//
// Build option: define RSP_ARB_FIXED_PRIO_EN for a fixed-priority grant, where the
// lowest-index non-empty channel wins. The default build is round-robin.

module rsp_arbiter_n #(
  parameter int unsigned RSP_WIDTH = 32,
  parameter int unsigned CH_NUM    = 4,
  parameter int unsigned BUF_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [CH_NUM-1:0]             rsp_write_en_i,
  input  logic [CH_NUM*RSP_WIDTH-1:0]   rsp_data_i,
  output logic [CH_NUM-1:0]             ch_full_o,
  output logic [CH_NUM-1:0]             ovf_o,
  input  logic                          ovf_clr,
  input  logic                          rsp_full,
  output logic                          rsp_write_en,
  output logic [RSP_WIDTH-1:0]          rsp_data
);

  localparam int unsigned PtrW = $clog2(BUF_DEPTH);
  localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);
  localparam int unsigned GntW = $clog2(CH_NUM);
  localparam logic [CntW-1:0] DepthCnt = CntW'(BUF_DEPTH);

  logic [RSP_WIDTH-1:0] mem_q [CH_NUM][BUF_DEPTH];

  logic [PtrW-1:0] wr_ptr_q [CH_NUM];
  logic [PtrW-1:0] wr_ptr_d [CH_NUM];
  logic [PtrW-1:0] rd_ptr_q [CH_NUM];
  logic [PtrW-1:0] rd_ptr_d [CH_NUM];
  logic [CntW-1:0] count_q  [CH_NUM];
  logic [CntW-1:0] count_d  [CH_NUM];

  logic [CH_NUM-1:0]    ovf_q, ovf_d;
  logic                 rsp_write_en_q, rsp_write_en_d;
  logic [RSP_WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic [CH_NUM-1:0] nonempty, full, push_ok, pop;
  logic              gnt_valid;
  logic [GntW-1:0]   gnt_idx;

  // Occupancy is taken from the registered count only, so a push to a full buffer is
  // dropped even when that channel is popped in the same cycle.
  always_comb begin
    nonempty = '0;
    full     = '0;
    push_ok  = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      nonempty[i] = (count_q[i] != '0);
      full[i]     = (count_q[i] == DepthCnt);
      push_ok[i]  = rsp_write_en_i[i] && !full[i];
    end
  end

`ifdef RSP_ARB_FIXED_PRIO_EN
  // Scan from high to low so the lowest-index non-empty channel is the last assignment.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (!rsp_full && nonempty[i]) begin
        gnt_valid = 1'b1;
        gnt_idx   = GntW'(i);
      end
    end
  end
`else
  logic [GntW-1:0] last_grant_q, last_grant_d;
  logic [GntW-1:0] cand;

  // Offsets are scanned from farthest to nearest, so the final assignment is the first
  // non-empty channel after last_grant_q in round-robin order.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int off = CH_NUM; off >= 1; off--) begin
      cand = GntW'((int'(last_grant_q) + off) % CH_NUM);
      if (!rsp_full && nonempty[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
    last_grant_d = gnt_valid ? gnt_idx : last_grant_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= GntW'(CH_NUM - 1);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  always_comb begin
    pop = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      pop[i] = gnt_valid && (gnt_idx == GntW'(i));
    end
  end

  // Pointer and count next state.
  always_comb begin
    for (int i = 0; i < CH_NUM; i++) begin
      wr_ptr_d[i] = push_ok[i] ? wr_ptr_q[i] + PtrW'(1) : wr_ptr_q[i];
      rd_ptr_d[i] = pop[i]     ? rd_ptr_q[i] + PtrW'(1) : rd_ptr_q[i];
      count_d[i]  = count_q[i];
      if (push_ok[i] && !pop[i]) begin
        count_d[i] = count_q[i] + CntW'(1);
      end else if (!push_ok[i] && pop[i]) begin
        count_d[i] = count_q[i] - CntW'(1);
      end
    end
  end

  // Sticky overflow: clear first, then a new drop sets its bit, so the set wins.
  always_comb begin
    ovf_d = ovf_clr ? '0 : ovf_q;
    ovf_d = ovf_d | (rsp_write_en_i & full);
  end

  always_comb begin
    rsp_write_en_d = gnt_valid;
    rsp_data_d     = gnt_valid ? mem_q[gnt_idx][rd_ptr_q[gnt_idx]] : '0;
  end

  // Buffer storage carries no reset; validity is tracked by the counts.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CH_NUM; i++) begin
      if (push_ok[i]) begin
        mem_q[i][wr_ptr_q[i]] <= rsp_data_i[i*RSP_WIDTH +: RSP_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CH_NUM; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      ovf_q          <= '0;
      rsp_write_en_q <= 1'b0;
      rsp_data_q     <= '0;
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        count_q[i]  <= count_d[i];
      end
      ovf_q          <= ovf_d;
      rsp_write_en_q <= rsp_write_en_d;
      rsp_data_q     <= rsp_data_d;
    end
  end

  assign ch_full_o    = full;
  assign ovf_o        = ovf_q;
  assign rsp_write_en = rsp_write_en_q;
  assign rsp_data     = rsp_data_q;

endmodule

// File: tb/tb_rsp_arbiter_n.sv
// Directed bench for rsp_arbiter_n in its default round-robin build
// (RSP_WIDTH=32, CH_NUM=4, BUF_DEPTH=4).
module tb_rsp_arbiter_n;
  localparam int unsigned W = 32;
  localparam int unsigned N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   wen_i;
  logic [N*W-1:0] data_i;
  logic [N-1:0]   ch_full;
  logic [N-1:0]   ovf;
  logic           ovf_clr;
  logic           rsp_full;
  logic           wen;
  logic [W-1:0]   data;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rsp_arbiter_n #(
    .RSP_WIDTH (W),
    .CH_NUM    (N),
    .BUF_DEPTH (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rsp_write_en_i (wen_i),
    .rsp_data_i     (data_i),
    .ch_full_o      (ch_full),
    .ovf_o          (ovf),
    .ovf_clr        (ovf_clr),
    .rsp_full       (rsp_full),
    .rsp_write_en   (wen),
    .rsp_data       (data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int ch, input logic [31:0] val);
    wen_i[ch] = 1'b1;
    data_i[ch*W +: W] = val;
  endtask

  initial begin
    rst_n    = 1'b0;
    wen_i    = '0;
    data_i   = '0;
    ovf_clr  = 1'b0;
    rsp_full = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("reset_wen", 32'(wen), 32'h0);
    chk("reset_data", data, 32'h0);
    chk("reset_ovf", 32'(ovf), 32'h0);
    chk("reset_full", 32'(ch_full), 32'h0);

    // Single push on ch2: the write appears on the second edge after the push.
    push(2, 32'hA0);
    tick();
    wen_i = '0;
    chk("lat_early_wen", 32'(wen), 32'h0);
    tick();
    chk("lat_wen", 32'(wen), 32'h1);
    chk("lat_data", data, 32'hA0);
    tick();
    chk("lat_idle_wen", 32'(wen), 32'h0);
    chk("lat_idle_data", data, 32'h0);

    // Reset again so channel 0 is served first.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) push(c, 32'h10 + 32'(c));
    tick();
    wen_i = '0;
    chk("same_early_wen", 32'(wen), 32'h0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("same_wen", 32'(wen), 32'h1);
      chk("same_data", data, 32'h10 + 32'(c));
    end
    tick();
    chk("same_idle", 32'(wen), 32'h0);

    // All channels backlogged: channel order 0,1,2,3,0,... and per-channel FIFO order.
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 4; c++) push(c, (32'(c) << 8) | 32'(k));
      tick();
      if (k >= 1) begin
        chk("rr_wen", 32'(wen), 32'h1);
        chk("rr_data", data, (32'((k - 1) % 4) << 8) | 32'((k - 1) / 4));
      end
    end
    wen_i = '0;
    tick();
    chk("rr_last_data", data, (32'h3 << 8) | 32'h1);
    chk("rr_ovf", 32'(ovf), 32'hF);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("rr_ovf_clr", 32'(ovf), 32'h0);
    repeat (20) tick();
    chk("rr_drained", 32'(wen), 32'h0);

    // Stall: fill ch1 with rsp_full held, fifth word dropped.
    rsp_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      push(1, 32'h50 + 32'(k));
      tick();
      chk("stall_no_wen", 32'(wen), 32'h0);
      if (k == 3) begin
        chk("stall_full4", 32'(ch_full), 32'h2);
        chk("stall_ovf4", 32'(ovf), 32'h0);
      end
    end
    wen_i = '0;
    chk("stall_ovf", 32'(ovf), 32'h2);
    chk("stall_full", 32'(ch_full), 32'h2);
    rsp_full = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("stall_rel_wen", 32'(wen), 32'h1);
      chk("stall_rel_data", data, 32'h50 + 32'(k));
    end
    tick();
    chk("stall_done_wen", 32'(wen), 32'h0);
    chk("stall_done_full", 32'(ch_full), 32'h0);

    // Clear coinciding with a new overflow on ch3: the set wins, ch1's flag clears.
    rsp_full = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push(3, 32'h30 + 32'(k));
      tick();
    end
    chk("clr_full3", 32'(ch_full), 32'h8);
    push(3, 32'h34);
    ovf_clr = 1'b1;
    tick();
    wen_i   = '0;
    ovf_clr = 1'b0;
    chk("clr_set_wins", 32'(ovf), 32'h8);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("clr_alone", 32'(ovf), 32'h0);
    rsp_full = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("clr_drain_data", data, 32'h30 + 32'(k));
    end
    tick();
    chk("clr_drain_idle", 32'(wen), 32'h0);

    // Mid-operation reset with words buffered on ch2 and a write in flight.
    rsp_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push(2, 32'hB0 + 32'(k));
      tick();
    end
    wen_i    = '0;
    rsp_full = 1'b0;
    tick();
    chk("mrst_pre_data", data, 32'hB0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_wen", 32'(wen), 32'h0);
    chk("mrst_data", data, 32'h0);
    chk("mrst_full", 32'(ch_full), 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mrst_no_wen", 32'(wen), 32'h0);
    end
    // last_grant was 2 before reset; after reset ch0 must beat ch3.
    push(0, 32'hC0);
    push(3, 32'hC3);
    tick();
    wen_i = '0;
    chk("mrst_early_wen", 32'(wen), 32'h0);
    tick();
    chk("mrst_first_wen", 32'(wen), 32'h1);
    chk("mrst_first_data", data, 32'hC0);
    tick();
    chk("mrst_second_data", data, 32'hC3);
    tick();
    chk("mrst_idle", 32'(wen), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rsp_arbiter_n.md
# rsp_arbiter_n

Parametrised N-channel response arbiter. It merges `CH_NUM` independent response producers onto the single response-FIFO write port. Each channel has a small private buffer, and channels are granted round-robin. The block honours a downstream almost-full stall and flags per-channel overflow. It replaces the two-input fixed arbiter wherever more than two engines (alloc, free, query, …) report into the shared response path.

## Interface

Parameters:
- `RSP_WIDTH`, 32, width of one response word.
- `CH_NUM`, 4, number of producer channels (2..16).
- `BUF_DEPTH`, 4, words per channel buffer (power of two, ≥2).

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `rsp_write_en_i`  in  CH_NUM  per-channel push strobe; bit i = channel i.
- `rsp_data_i`  in  CH_NUM*RSP_WIDTH  per-channel data; channel i at `[i*RSP_WIDTH +: RSP_WIDTH]`.
- `ch_full_o`  out  CH_NUM  channel buffer holds `BUF_DEPTH` words.
- `ovf_o`  out  CH_NUM  sticky: a push was dropped on channel i.
- `ovf_clr`  in  1  clears all `ovf_o` bits.
- `rsp_full`  in  1  downstream almost-full; suppresses new grants.
- `rsp_write_en`  out  1  registered write strobe to the response FIFO.
- `rsp_data`  out  RSP_WIDTH  registered write data.

## Operation

- Per channel there is a circular buffer, a `wr_ptr`/`rd_ptr` of `$clog2(BUF_DEPTH)` bits, and a `count` of `$clog2(BUF_DEPTH+1)` bits. Pointers wrap naturally at `BUF_DEPTH`.
- Push:
  - When `rsp_write_en_i[i]` is high and `count_i < BUF_DEPTH`, the word is stored.
  - When the buffer is full, the word is dropped and `ovf_o[i]` is set.
  - Fullness is judged on `count` at the start of the cycle. A push to a full buffer is dropped even if the same channel is popped that cycle.
- Grant:
  - When `rsp_full` is low and at least one buffer is non-empty, exactly one channel is granted per cycle.
  - The search starts at `last_grant+1` and wraps modulo `CH_NUM`. The first non-empty channel wins, and `last_grant` updates to the winner.
  - While `rsp_full` is high, no channel is granted and `last_grant` holds.
- Pop: the granted channel's head word is registered into `rsp_data`, `rsp_write_en` is driven high for one cycle, and `rd_ptr` advances.
- Simultaneous push and pop on a non-full channel: both take effect and `count` is unchanged.
- `ovf_clr`: clears all `ovf_o` bits. If it coincides with a new overflow, the set wins.
- Outputs when no grant: `rsp_write_en` = 0 and `rsp_data` = 0; data is never left stale.
- No word is ever reordered within a channel, and no accepted word is lost.

## Timing

- Reset values (`rst_n` low at a rising edge): `rsp_write_en`=0, `rsp_data`=0, `ovf_o`=0, all counts and pointers 0, `ch_full_o`=0, `last_grant`=`CH_NUM-1` (channel 0 is served first). Buffer RAM contents are don't-care.
- A reset asserted mid-operation discards all buffered words at that edge. A write in flight on `rsp_write_en` is not emitted after that edge.
- Latency: a push accepted at edge t is grantable in cycle t+1 and appears on `rsp_write_en`/`rsp_data` in cycle t+2 (2 cycles minimum).
- Throughput: 1 word per cycle aggregate. With all channels backlogged, each channel gets exactly 1 of every `CH_NUM` slots.
- `rsp_full` is sampled in the grant cycle. One write already registered may still appear in the cycle after `rsp_full` rises, so downstream must assert it with at least one free slot.
- `ch_full_o` is registered state and is valid in the same cycle a producer would push.

## Configuration

- `RSP_ARB_FIXED_PRIO_EN`
  - Defined: the grant is fixed-priority, with the lowest-index non-empty channel winning. `last_grant` is not implemented.
  - Undefined (default): round-robin as described above.
- All other behaviour is identical in both builds.

## Test plan

- Reset, then push 0xA0 on ch2 only → `rsp_write_en`=1 with `rsp_data`=0xA0 exactly 2 cycles after the push; all other outputs idle.
- Same-cycle pushes 0x10,0x11,0x12,0x13 on ch0..ch3 → emitted in order 0x10,0x11,0x12,0x13 on 4 consecutive cycles; with `RSP_ARB_FIXED_PRIO_EN` the order is the same.
- All 4 channels continuously pushed → output channel sequence 0,1,2,3,0,1,… with no gaps. With `RSP_ARB_FIXED_PRIO_EN`, only ch0 is served until its pushes stop.
- Hold `rsp_full`=1 while pushing 5 words on ch1 (`BUF_DEPTH`=4):
  - `ch_full_o[1]`=1 after the 4th word and the 5th word is dropped.
  - `ovf_o[1]`=1 and no writes occur except at most one in the cycle after `rsp_full` rises.
  - Releasing `rsp_full` → 4 words emitted in order.
- Pulse `ovf_clr` in the same cycle as a new overflow on ch3 → `ovf_o[3]` stays 1. A subsequent clear alone → 0.
- Assert `rst_n`=0 for 1 cycle with 3 words buffered → no further writes; next push emits after 2 cycles; `last_grant` has restarted so ch0 is served first.
